// File: rtl/mem_port_arbiter_if.sv
// Bus bundle tying the fetch/data requesters and the unified memory to the arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 64
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_cancel;
    logic              f_done;
    logic [79:0]       f_data;
    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [63:0]       m_wdata;
    logic              m_done;
    logic [63:0]       m_rdata;
    logic              f_stall;
    logic              m_stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic              mem_ready;
    logic [79:0]       mem_rdata;
    logic [2:0]        err_stat;

    modport master (
        input  f_req, f_addr, f_cancel, m_req, m_we, m_addr, m_wdata, mem_ready, mem_rdata,
        output f_done, f_data, m_done, m_rdata, f_stall, m_stall,
               mem_req, mem_we, mem_addr, mem_wdata, err_stat
    );

    modport slave (
        output f_req, f_addr, f_cancel, m_req, m_we, m_addr, m_wdata, mem_ready, mem_rdata,
        input  f_done, f_data, m_done, m_rdata, f_stall, m_stall,
               mem_req, mem_we, mem_addr, mem_wdata, err_stat
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the data stage (data has priority).
// Define MEM_ARB_TIMEOUT_EN to add a watchdog that aborts stuck accesses and sets err_stat = 3.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W         = 64,
    parameter int unsigned MAX_M_STREAK   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus
);
    localparam int unsigned F_DATA_W = 80;
    localparam int unsigned M_DATA_W = 64;
    localparam int unsigned STREAK_W = $clog2(MAX_M_STREAK + 1);

    if (MAX_M_STREAK == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_param
        $error("mem_port_arbiter: MAX_M_STREAK and TIMEOUT_CYCLES must be non-zero");
    end

    typedef enum logic [1:0] {IDLE, BUSY_F, BUSY_M, RESP} state_e;

    state_e                state_q, state_d;
    logic [STREAK_W-1:0]   streak_q, streak_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [M_DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                  f_done_q, f_done_d;
    logic                  m_done_q, m_done_d;
    logic [F_DATA_W-1:0]   f_data_q, f_data_d;
    logic [M_DATA_W-1:0]   m_rdata_q, m_rdata_d;
    logic                  cancel_q, cancel_d;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [2:0]  ERR_TIMEOUT = 3'd3;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [2:0]            err_stat_q, err_stat_d;
`endif

    logic streak_at_max;
    logic fetch_killed;

    assign streak_at_max = (streak_q == STREAK_W'(MAX_M_STREAK));
    // A cancel seen at any point of the fetch, including the completing edge, discards its result.
    assign fetch_killed  = cancel_q | bus.f_cancel;

    // Next-state, arbitration and response capture.
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        f_done_d    = 1'b0;
        m_done_d    = 1'b0;
        f_data_d    = f_data_q;
        m_rdata_d   = m_rdata_q;
        cancel_d    = cancel_q;
`ifdef MEM_ARB_TIMEOUT_EN
        tmo_d       = tmo_q;
        err_stat_d  = err_stat_q;
`endif
        case (state_q)
            IDLE: begin
                cancel_d = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
                tmo_d    = '0;
`endif
                if (bus.m_req && !(bus.f_req && streak_at_max)) begin
                    state_d     = BUSY_M;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.m_we;
                    mem_addr_d  = bus.m_addr;
                    mem_wdata_d = bus.m_wdata;
                    if (bus.f_req) begin
                        streak_d = streak_at_max ? streak_q : streak_q + STREAK_W'(1);
                    end else begin
                        streak_d = '0;
                    end
                end else if (bus.f_req && !bus.f_cancel) begin
                    state_d     = BUSY_F;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.f_addr;
                    mem_wdata_d = '0;
                    streak_d    = '0;
                end
            end
            BUSY_F, BUSY_M: begin
                if (state_q == BUSY_F && bus.f_cancel) begin
                    cancel_d = 1'b1;
                end
                if (bus.mem_ready) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (state_q == BUSY_F) begin
                        if (!fetch_killed) begin
                            f_done_d = 1'b1;
                            f_data_d = bus.mem_rdata;
                        end
                    end else begin
                        m_done_d = 1'b1;
                        if (!mem_we_q) begin
                            m_rdata_d = bus.mem_rdata[M_DATA_W-1:0];
                        end
                    end
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d    = RESP;
                    mem_req_d  = 1'b0;
                    err_stat_d = ERR_TIMEOUT;
                    if (state_q == BUSY_F) begin
                        if (!fetch_killed) begin
                            f_done_d = 1'b1;
                            f_data_d = '0;
                        end
                    end else begin
                        m_done_d  = 1'b1;
                        m_rdata_d = '0;
                    end
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            f_done_q    <= 1'b0;
            m_done_q    <= 1'b0;
            f_data_q    <= '0;
            m_rdata_q   <= '0;
            cancel_q    <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_q       <= '0;
            err_stat_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            f_done_q    <= f_done_d;
            m_done_q    <= m_done_d;
            f_data_q    <= f_data_d;
            m_rdata_q   <= m_rdata_d;
            cancel_q    <= cancel_d;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_q       <= tmo_d;
            err_stat_q  <= err_stat_d;
`endif
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.f_done    = f_done_q;
    assign bus.m_done    = m_done_q;
    assign bus.f_data    = f_data_q;
    assign bus.m_rdata   = m_rdata_q;
    // Stalls feed hazard control in the same cycle, so they stay combinational.
    assign bus.f_stall   = bus.f_req & ~f_done_q;
    assign bus.m_stall   = bus.m_req & ~m_done_q;
`ifdef MEM_ARB_TIMEOUT_EN
    assign bus.err_stat  = err_stat_q;
`else
    assign bus.err_stat  = 3'd0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: requester queues, a latency-controlled memory model and an in-order scoreboard.
module tb_mem_port_arbiter;
    localparam int unsigned ADDR_W = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .MAX_M_STREAK(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct { logic is_f; logic [79:0] data; } exp_t;
    typedef struct { logic we; logic [63:0] addr; logic [63:0] wdata; } mop_t;

    exp_t        sb[$];
    mop_t        mq[$];
    logic [63:0] fq[$];
    logic [79:0] mem  [logic [63:0]];
    logic [79:0] refm [logic [63:0]];

    int n_vec, n_err, wait_cnt, ready_lat, cnt;
    bit mem_auto;
    logic [63:0] exp_m;
    logic [79:0] last_f;

    logic        s_mem_req, s_mem_we, s_f_done, s_m_done, s_f_stall, s_m_stall;
    logic [63:0] s_mem_addr, s_mem_wdata, s_m_rdata;
    logic [79:0] s_f_data;
    logic [2:0]  s_err;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] dflt(input logic [63:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a};
    endfunction

    function automatic logic [79:0] exp_rd(input logic [63:0] a);
        return refm.exists(a) ? refm[a] : dflt(a);
    endfunction

    function automatic logic [79:0] mem_rd(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : dflt(a);
    endfunction

    task automatic preload(input logic [63:0] a, input logic [79:0] d);
        mem[a]  = d;
        refm[a] = d;
    endtask

    task automatic present();
        bus.f_req  = (fq.size() != 0);
        bus.f_addr = (fq.size() != 0) ? fq[0] : 64'h0;
        if (mq.size() != 0) begin
            bus.m_req   = 1'b1;
            bus.m_we    = mq[0].we;
            bus.m_addr  = mq[0].addr;
            bus.m_wdata = mq[0].wdata;
        end else begin
            bus.m_req   = 1'b0;
            bus.m_we    = 1'b0;
            bus.m_addr  = 64'h0;
            bus.m_wdata = 64'h0;
        end
    endtask

    task automatic issue_f(input logic [63:0] a, input bit expect_done);
        fq.push_back(a);
        if (expect_done) sb.push_back('{1'b1, exp_rd(a)});
        present();
    endtask

    task automatic issue_m(input logic we, input logic [63:0] a, input logic [63:0] wd, input bit expect_done);
        logic [79:0] t;
        mq.push_back('{we, a, wd});
        if (expect_done) begin
            if (we) begin
                refm[a] = {16'h0, wd};
            end else begin
                t     = exp_rd(a);
                exp_m = t[63:0];
            end
            sb.push_back('{1'b0, {16'h0, exp_m}});
        end
        present();
    endtask

    // One cycle: sample at the falling edge, score done pulses, advance requesters and memory.
    task automatic step();
        exp_t e;
        @(negedge clk);
        s_mem_req   = bus.mem_req;
        s_mem_we    = bus.mem_we;
        s_mem_addr  = bus.mem_addr;
        s_mem_wdata = bus.mem_wdata;
        s_f_done    = bus.f_done;
        s_m_done    = bus.m_done;
        s_f_data    = bus.f_data;
        s_m_rdata   = bus.m_rdata;
        s_f_stall   = bus.f_stall;
        s_m_stall   = bus.m_stall;
        s_err       = bus.err_stat;
        if (s_f_done || s_m_done) begin
            chk("done_onehot", 80'(s_f_done & s_m_done), 80'(0));
            chk("done_expected", 80'(sb.size() == 0), 80'(0));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("done_owner", 80'(s_f_done), 80'(e.is_f));
                if (e.is_f) chk("f_data", s_f_data, e.data);
                else        chk("m_rdata", {16'h0, s_m_rdata}, e.data);
            end
        end
        if (s_f_done && fq.size() != 0) void'(fq.pop_front());
        if (s_m_done && mq.size() != 0) void'(mq.pop_front());
        present();
        if (s_mem_req) begin
            if (mem_auto && wait_cnt >= ready_lat) begin
                bus.mem_ready = 1'b1;
                if (s_mem_we) begin
                    mem[s_mem_addr] = {16'h0, s_mem_wdata};
                    bus.mem_rdata   = 80'hBAD0_BAD0_BAD0_BAD0_BAD0;
                end else begin
                    bus.mem_rdata = mem_rd(s_mem_addr);
                end
            end else begin
                bus.mem_ready = 1'b0;
                bus.mem_rdata = 80'hBAD0_BAD0_BAD0_BAD0_BAD0;
            end
            wait_cnt++;
        end else begin
            wait_cnt      = 0;
            bus.mem_ready = 1'b0;
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || fq.size() != 0 || mq.size() != 0) && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_drain"}, 80'(sb.size()), 80'(0));
        step();
    endtask

    initial begin
        n_vec = 0; n_err = 0; wait_cnt = 0; ready_lat = 0; mem_auto = 1'b1; exp_m = '0;
        rst = 1'b1;
        bus.f_cancel = 1'b0; bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        present();
        step(); step();
        rst = 1'b0;
        chk("rst_mem_req", 80'(s_mem_req), 80'(0));
        chk("rst_mem_addr", 80'(s_mem_addr), 80'(0));
        chk("rst_dones", 80'({s_f_done, s_m_done}), 80'(0));
        chk("rst_data", {s_f_data ^ 80'(s_m_rdata)}, 80'(0));
        chk("rst_err", 80'(s_err), 80'(0));

        // Single fetch with an immediately ready memory.
        preload(64'h100, 80'h30F4_0000_0000_0000_0005);
        issue_f(64'h100, 1'b1);
        #1 chk("fetch_stall_c0", 80'(bus.f_stall), 80'(1));
        step();
        chk("fetch_memreq_c1", 80'(s_mem_req), 80'(1));
        chk("fetch_addr_c1", 80'(s_mem_addr), 80'(64'h100));
        chk("fetch_we_c1", 80'(s_mem_we), 80'(0));
        chk("fetch_stall_c1", 80'(s_f_stall), 80'(1));
        step();
        chk("fetch_done_c2", 80'(s_f_done), 80'(1));
        chk("fetch_stall_c2", 80'(s_f_stall), 80'(0));
        wait_idle("fetch", 20);

        // Simultaneous requests: data first, fetch granted after RESP.
        preload(64'h200, 80'hDEAD);
        issue_m(1'b0, 64'h200, 64'h0, 1'b1);
        issue_f(64'h300, 1'b1);
        step();
        chk("sim_addr_c1", 80'(s_mem_addr), 80'(64'h200));
        step();
        chk("sim_mdone_c2", 80'({s_m_done, s_f_done}), 80'(2'b10));
        step();
        chk("sim_idle_c3", 80'(s_mem_req), 80'(0));
        step();
        chk("sim_fetch_c4", 80'({s_mem_req, s_mem_addr}), {15'h0, 1'b1, 64'h300});
        wait_idle("sim", 20);

        // Streak limit: four data grants, then fetch, twice over.
        issue_m(1'b0, 64'hA00, 64'h0, 1'b1);
        issue_m(1'b1, 64'hA08, 64'h1122_3344_5566_7788, 1'b1);
        issue_m(1'b0, 64'hA08, 64'h0, 1'b1);
        issue_m(1'b1, 64'hA10, 64'h0BAD_F00D_0000_0001, 1'b1);
        issue_f(64'hF00, 1'b1);
        issue_m(1'b0, 64'hA10, 64'h0, 1'b1);
        issue_m(1'b0, 64'hA18, 64'h0, 1'b1);
        issue_m(1'b0, 64'hA20, 64'h0, 1'b1);
        issue_m(1'b0, 64'hA28, 64'h0, 1'b1);
        issue_f(64'hF10, 1'b1);
        issue_m(1'b0, 64'hA30, 64'h0, 1'b1);
        wait_idle("streak", 200);

        // Cancel while idle blocks the fetch grant for that cycle.
        bus.f_cancel = 1'b1;
        issue_f(64'h400, 1'b1);
        step();
        chk("idle_cancel_blocks", 80'(s_mem_req), 80'(0));
        bus.f_cancel = 1'b0;
        wait_idle("idle_cancel", 20);
        last_f = exp_rd(64'h400);

        // Cancel in BUSY_F: memory completes, no f_done, f_data kept.
        ready_lat = 3;
        issue_f(64'h500, 1'b0);
        step();
        chk("cancel_busy", 80'({s_mem_req, s_mem_addr}), {15'h0, 1'b1, 64'h500});
        bus.f_cancel = 1'b1;
        fq.delete();
        present();
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            bus.f_cancel = 1'b0;
            if (s_mem_req) cnt++;
            chk("cancel_no_done", 80'(s_f_done), 80'(0));
        end
        chk("cancel_memreq_cycles", 80'(cnt), 80'(3));
        chk("cancel_f_data", s_f_data, last_f);
        ready_lat = 0;
        issue_m(1'b0, 64'h800, 64'h0, 1'b1);
        step();
        chk("cancel_then_idle", 80'({s_mem_req, s_mem_addr}), {15'h0, 1'b1, 64'h800});
        wait_idle("after_cancel", 20);

        // Reset in the middle of a data write.
        ready_lat = 50;
        issue_m(1'b1, 64'h600, 64'h5555_AAAA_0000_FFFF, 1'b0);
        step(); step();
        chk("midrst_busy", 80'({s_mem_req, s_mem_we}), 80'(2'b11));
        chk("midrst_wdata", 80'(s_mem_wdata), 80'(64'h5555_AAAA_0000_FFFF));
        rst = 1'b1;
        mq.delete();
        present();
        step();
        rst = 1'b0;
        exp_m = '0;
        chk("midrst_memreq", 80'({s_mem_req, s_mem_we, s_mem_addr}), 80'(0));
        chk("midrst_data", s_f_data | 80'(s_m_rdata), 80'(0));
        chk("midrst_dones", 80'({s_f_done, s_m_done}), 80'(0));
        ready_lat = 0;
        issue_f(64'h900, 1'b1);
        step();
        chk("midrst_then_idle", 80'(s_mem_req), 80'(1));
        wait_idle("midrst", 20);

        // Memory never answers a write.
        mem_auto = 1'b0;
        issue_m(1'b1, 64'hB00, 64'hCAFE, 1'b0);
        cnt = 0;
`ifdef MEM_ARB_TIMEOUT_EN
        sb.push_back('{1'b0, 80'h0});
        exp_m = '0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (s_mem_req) cnt++;
            if (s_m_done) break;
        end
        chk("tmo_memreq_cycles", 80'(cnt), 80'(8));
        chk("tmo_done", 80'(s_m_done), 80'(1));
        chk("tmo_err", 80'(s_err), 80'(3));
        mem_auto = 1'b1;
        wait_idle("tmo", 20);
        issue_m(1'b0, 64'hB08, 64'h0, 1'b1);
        wait_idle("tmo_after", 20);
        chk("tmo_err_sticky", 80'(s_err), 80'(3));
`else
        for (int i = 0; i < 20; i++) begin
            step();
            if (s_mem_req) cnt++;
        end
        chk("hang_memreq_cycles", 80'(cnt), 80'(20));
        chk("hang_err", 80'(s_err), 80'(0));
        rst = 1'b1;
        mq.delete();
        present();
        step();
        rst = 1'b0;
        mem_auto = 1'b1;
        chk("hang_rst_memreq", 80'(s_mem_req), 80'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage (instruction read, 10 bytes) and the memory stage (data read/write, 8 bytes).
- Sequences each access over a req/ready memory handshake and returns the result with a one-cycle done pulse.
- Raises stall outputs, which feed the pipeline hazard-control logic as extra F/M stall conditions.
- Memory stage has priority. A streak limit prevents fetch starvation.

Parameters:
- ADDR_W, 64, address width
- MAX_M_STREAK, 4, maximum consecutive data grants while fetch is waiting
- TIMEOUT_CYCLES, 255, watchdog limit (used only with the optional feature)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- f_req  input  1  fetch request; held until f_done
- f_addr  input  ADDR_W  fetch PC
- f_cancel  input  1  discard the in-flight or pending fetch (mispredict/ret redirect)
- f_done  output  1  one-cycle pulse; f_data valid
- f_data  output  80  instruction bytes
- m_req  input  1  data request; held until m_done
- m_we  input  1  1 = write, 0 = read
- m_addr  input  ADDR_W  data address
- m_wdata  input  64  write data
- m_done  output  1  one-cycle pulse; m_rdata valid
- m_rdata  output  64  read data
- f_stall  output  1  f_req && !f_done (combinational)
- m_stall  output  1  m_req && !m_done (combinational)
- mem_req  output  1  memory request, held until mem_ready
- mem_we  output  1  write enable to memory
- mem_addr  output  ADDR_W  registered address
- mem_wdata  output  64  registered write data
- mem_ready  input  1  memory has accepted/completed the access this cycle
- mem_rdata  input  80  read data, valid with mem_ready
- err_stat  output  3  0 = none, 3 = SADR timeout (optional feature only)

Behaviour:
- Reset (synchronous; overrides everything, including an access in flight):
  - state = IDLE, streak = 0.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, f_done, m_done, f_data, m_rdata, err_stat.
- States: IDLE, BUSY_F, BUSY_M, RESP.
- IDLE arbitration, sampled at the clock edge:
  - m_req && !(f_req && streak == MAX_M_STREAK) → BUSY_M.
  - Else f_req && !f_cancel → BUSY_F.
  - On either grant, load mem_addr/mem_we/mem_wdata and set mem_req = 1 from the next cycle.
  - For fetch grants, mem_we = 0 and mem_wdata = 0.
- streak:
  - Increments on each data grant made while f_req is high (saturates at MAX_M_STREAK).
  - Clears on any fetch grant, or on a data grant with f_req low.
- BUSY_x: hold mem_req and all mem_* outputs stable until mem_ready is sampled high. Then:
  - mem_req drops at that edge; go to RESP.
  - Capture data: BUSY_F → f_data = mem_rdata; BUSY_M read → m_rdata = mem_rdata[63:0]; BUSY_M write leaves m_rdata unchanged.
- RESP (exactly one cycle):
  - Pulse f_done or m_done for the owner; no arbitration in this cycle; return to IDLE.
- Minimum latency: request sampled at edge N, mem_req high during cycle N+1, done high during cycle N+2 (mem_ready = 1 immediately). Back-to-back grant spacing is 3 cycles minimum.
- f_cancel while in BUSY_F:
  - The access completes on the memory side (mem_req never dropped early).
  - f_done is suppressed in RESP and f_data is not updated.
- f_cancel in IDLE blocks the fetch grant that cycle.
- Simultaneous f_req and m_req: data wins unless the streak limit is reached, in which case fetch wins.
- done pulses never overlap; at most one of f_done/m_done is high per cycle.
- Requesters deasserting req while granted: ignored; the access completes and done still pulses.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in BUSY_x and clears on grant.
  - If it reaches TIMEOUT_CYCLES without mem_ready: drop mem_req, go to RESP, pulse the owner's done with data 0, and set err_stat = 3 (sticky until rst).
- Undefined:
  - No counter; BUSY_x waits indefinitely; err_stat tied to 0.

Test Plan:
- Reset mid-access: rst in BUSY_M with mem_req = 1 → next cycle mem_req = 0, state IDLE, all done/data outputs 0.
- Single fetch: f_req, f_addr = 0x100, mem_ready = 1 immediately, mem_rdata = 0x30F4_0000_0000_0000_0005 → mem_req in cycle 1, f_done in cycle 2 with f_data equal to that value, f_stall high cycles 0–1.
- Simultaneous requests: f_req and m_req (read 0x200, rdata 0xDEAD) → data served first; fetch granted in cycle 3 after RESP; m_done precedes f_done.
- Streak limit: m_req held continuously with f_req, MAX_M_STREAK = 4 → exactly 4 data grants, then a fetch grant, then streak resets.
- Cancel: f_cancel pulsed in BUSY_F, mem_ready 3 cycles later → no f_done pulse, f_data unchanged, arbiter back in IDLE.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8): mem_ready held 0 on a write → mem_req drops after 8 cycles, m_done pulses, err_stat = 3; without the macro, mem_req stays high.
